// File: rtl/bch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bch_pkg
//  Purpose  : Shared constants, FSM state type and GF(16) arithmetic for the
//             BCH(15,7) t=2 decoder.
//  Revision : 1.0  initial release
// ============================================================================
package bch_pkg;

  // Generator polynomial g(x) = x^8+x^7+x^6+x^4+1
  localparam logic [8:0] GEN_POLY   = 9'h1D1;
  // Field polynomial x^4+x+1; alpha is the element x
  localparam logic [4:0] PRIM_POLY  = 5'h13;
  localparam logic [3:0] GF16_ALPHA = 4'h2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYND   = 3'd1,
    ST_SOLVE  = 3'd2,
    ST_CHIEN  = 3'd3,
    ST_DIVIDE = 3'd4,
    ST_DONE   = 3'd5
  } bch_dec_state_t;

  // Antilog: entry e holds alpha^e. Entry 15 wraps to alpha^0 so that
  // "15 - log" can be used directly as the inverse exponent.
  localparam logic [15:0][3:0] GF16_ALOG = {
    4'h1, 4'h9, 4'hD, 4'hF, 4'hE, 4'h7, 4'hA, 4'h5,
    4'hB, 4'hC, 4'h6, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1
  };

  // Log: entry v holds e with alpha^e = v (entry 0 is unused)
  localparam logic [15:0][3:0] GF16_LOG = {
    4'hC, 4'hB, 4'hD, 4'h6, 4'h7, 4'h9, 4'hE, 4'h3,
    4'hA, 4'h5, 4'h8, 4'h2, 4'h4, 4'h1, 4'h0, 4'h0
  };

  // Shift-and-add multiply reduced modulo PRIM_POLY
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] x;
    acc = 4'h0;
    x   = a;
    for (int k = 0; k < 4; k++) begin
      if (b[k]) acc = acc ^ x;
      x = x[3] ? ({x[2:0], 1'b0} ^ PRIM_POLY[3:0]) : {x[2:0], 1'b0};
    end
    return acc;
  endfunction

  // a^e for e in 0..15
  function automatic logic [3:0] gf16_pow(input logic [3:0] a, input logic [3:0] e);
    logic [3:0] r;
    r = 4'h1;
    for (int k = 0; k < 15; k++) begin
      if (k < int'(e)) r = gf16_mul(r, a);
    end
    return r;
  endfunction

  // Multiplicative inverse of a non-zero element via the log tables
  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    return GF16_ALOG[4'd15 - GF16_LOG[a]];
  endfunction

endpackage : bch_pkg
`default_nettype wire

// File: rtl/bch_syndrome_calc.sv
`default_nettype none
// ============================================================================
//  Module   : bch_syndrome_calc
//  Purpose  : Serial S1/S3 syndrome evaluation by Horner's rule, highest
//             coefficient first. start_i loads the word; last_o marks the
//             cycle whose closing edge performs the 15th and final step.
//  Revision : 1.0  initial release
// ============================================================================
module bch_syndrome_calc
  import bch_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        start_i,
  input  logic [14:0] codeword_i,
  output logic        last_o,
  output logic [3:0]  s1_o,
  output logic [3:0]  s3_o
);

  localparam logic [3:0] ALPHA3 = gf16_pow(GF16_ALPHA, 4'd3);

  logic [14:0] word_q;
  logic [3:0]  s1_q;
  logic [3:0]  s3_q;
  logic [3:0]  cnt_q;
  logic        active_q;
  logic [3:0]  coef;

  assign coef   = {3'b000, word_q[14]};
  assign last_o = active_q && (cnt_q == 4'd14);
  assign s1_o   = s1_q;
  assign s3_o   = s3_q;

  // Load on start, then fold one coefficient per cycle into both syndromes
  always_ff @(posedge clk) begin
    if (!rstn) begin
      word_q   <= '0;
      s1_q     <= '0;
      s3_q     <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start_i) begin
      word_q   <= codeword_i;
      s1_q     <= '0;
      s3_q     <= '0;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      s1_q   <= gf16_mul(s1_q, GF16_ALPHA) ^ coef;
      s3_q   <= gf16_mul(s3_q, ALPHA3) ^ coef;
      word_q <= {word_q[13:0], 1'b0};
      cnt_q  <= cnt_q + 4'd1;
      if (cnt_q == 4'd14) active_q <= 1'b0;
    end
  end

endmodule : bch_syndrome_calc
`default_nettype wire

// File: rtl/bch_decoder_15_7.sv
`default_nettype none
// ============================================================================
//  Module   : bch_decoder_15_7
//  Purpose  : BCH(15,7) t=2 decoder for the non-systematic code c = m*g.
//             Syndromes -> Peterson solve -> Chien correction -> division
//             by g(x). Fixed 38-cycle latency from capture to out_valid.
//  Options  : define BCH_DEC_STATS_EN to add saturating frame counters.
//  Revision : 1.0  initial release
// ============================================================================
module bch_decoder_15_7
  import bch_pkg::*;
#(
  parameter int N = 15,
  parameter int K = 7
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_codeword,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] out_message,
  output logic [N-1:0] out_corrected,
  output logic [1:0]   out_num_err,
  output logic         out_uncorrectable,
  output logic         busy
`ifdef BCH_DEC_STATS_EN
  ,
  input  logic         stat_clr,
  output logic [15:0]  stat_corrected,
  output logic [15:0]  stat_uncorr
`endif
);

  bch_dec_state_t state_q, state_d;

  logic         syn_start;
  logic         syn_last;
  logic [3:0]   s1, s3;

  logic [N-1:0] rx_q, flip_q, corr_q, rem_q;
  logic [3:0]   sig1_q, sig2_q, cnt_q, roots_q;
  logic [1:0]   deg_q, nerr_q;
  logic         synd_fail_q, fail_q;
  logic [K-2:0] quot_q;

  logic [K-1:0] msg_q;
  logic [N-1:0] corr_out_q;
  logic [1:0]   num_err_q;
  logic         uncorr_q;

  bch_syndrome_calc u_synd (
    .clk        (clk),
    .rstn       (rstn),
    .start_i    (syn_start),
    .codeword_i (in_codeword),
    .last_o     (syn_last),
    .s1_o       (s1),
    .s3_o       (s3)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: fixed phase lengths so latency never depends on error count
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (in_valid)             state_d = ST_SYND;
      ST_SYND:   if (syn_last)             state_d = ST_SOLVE;
      ST_SOLVE:                            state_d = ST_CHIEN;
      ST_CHIEN:  if (cnt_q == 4'd14)       state_d = ST_DIVIDE;
      ST_DIVIDE: if (cnt_q == 4'd6)        state_d = ST_DONE;
      ST_DONE:   if (out_ready)            state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    out_valid = (state_q == ST_DONE);
    syn_start = in_valid && (state_q == ST_IDLE);
  end

  // Peterson solve for sigma(x) = 1 + sigma1*x + sigma2*x^2
  logic [3:0] s1_cube, sig1_d, sig2_d;
  logic [1:0] deg_d;
  logic       synd_fail_d;
  always_comb begin
    s1_cube     = gf16_mul(gf16_mul(s1, s1), s1);
    sig1_d      = 4'h0;
    sig2_d      = 4'h0;
    deg_d       = 2'd0;
    synd_fail_d = 1'b0;
    if (s1 == 4'h0) begin
      synd_fail_d = (s3 != 4'h0);
    end else if (s3 == s1_cube) begin
      sig1_d = s1;
      deg_d  = 2'd1;
    end else begin
      sig1_d = s1;
      sig2_d = gf16_mul(s3 ^ s1_cube, gf16_inv(s1));
      deg_d  = 2'd2;
    end
  end

  // Chien evaluation of sigma at alpha^-i for the current position i = cnt_q
  logic [3:0]   neg1, chien_eval, roots_d;
  logic [4:0]   neg2;
  logic         chien_hit, chien_fail;
  logic [N-1:0] flip_d, chien_word;
  always_comb begin
    neg1 = 4'd15 - cnt_q;
    neg2 = {neg1, 1'b0};
    if (neg2 >= 5'd15) neg2 = neg2 - 5'd15;
    chien_eval = 4'h1 ^ gf16_mul(sig1_q, GF16_ALOG[neg1])
                      ^ gf16_mul(sig2_q, GF16_ALOG[neg2[3:0]]);
    chien_hit  = (chien_eval == 4'h0);
    flip_d     = flip_q;
    if (chien_hit) flip_d[cnt_q] = 1'b1;
    roots_d    = roots_q + {3'b000, chien_hit};
    // A root count that disagrees with the locator degree means >2 errors
    chien_fail = synd_fail_q || (roots_d != {2'b00, deg_q});
    chien_word = chien_fail ? rx_q : (rx_q ^ flip_d);
  end

  // One long-division step by g(x), working down from x^14
  logic [3:0]   div_pos;
  logic         div_bit, final_uncorr;
  logic [N-1:0] div_mask, rem_d;
  always_comb begin
    div_pos      = 4'd14 - cnt_q;
    div_bit      = rem_q[div_pos];
    div_mask     = {6'b000000, GEN_POLY} << (4'd6 - cnt_q);
    rem_d        = div_bit ? (rem_q ^ div_mask) : rem_q;
    // A non-zero remainder means the corrected word is not a codeword
    final_uncorr = fail_q || (rem_d[7:0] != 8'h00);
  end

  // Datapath: capture, solve, correct, divide; outputs update only at the end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_q        <= '0;
      flip_q      <= '0;
      corr_q      <= '0;
      rem_q       <= '0;
      sig1_q      <= '0;
      sig2_q      <= '0;
      cnt_q       <= '0;
      roots_q     <= '0;
      deg_q       <= '0;
      nerr_q      <= '0;
      synd_fail_q <= 1'b0;
      fail_q      <= 1'b0;
      quot_q      <= '0;
      msg_q       <= '0;
      corr_out_q  <= '0;
      num_err_q   <= '0;
      uncorr_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (syn_start) rx_q <= in_codeword;
        end
        ST_SOLVE: begin
          sig1_q      <= sig1_d;
          sig2_q      <= sig2_d;
          deg_q       <= deg_d;
          synd_fail_q <= synd_fail_d;
          cnt_q       <= '0;
          flip_q      <= '0;
          roots_q     <= '0;
        end
        ST_CHIEN: begin
          flip_q  <= flip_d;
          roots_q <= roots_d;
          if (cnt_q == 4'd14) begin
            cnt_q  <= '0;
            fail_q <= chien_fail;
            nerr_q <= chien_fail ? 2'd0 : deg_q;
            corr_q <= chien_word;
            rem_q  <= chien_word;
            quot_q <= '0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_DIVIDE: begin
          rem_q  <= rem_d;
          quot_q <= {quot_q[K-3:0], div_bit};
          cnt_q  <= cnt_q + 4'd1;
          if (cnt_q == 4'd6) begin
            msg_q      <= {quot_q, div_bit};
            corr_out_q <= corr_q;
            uncorr_q   <= final_uncorr;
            num_err_q  <= final_uncorr ? 2'd0 : nerr_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_message       = msg_q;
  assign out_corrected     = corr_out_q;
  assign out_num_err       = num_err_q;
  assign out_uncorrectable = uncorr_q;

`ifdef BCH_DEC_STATS_EN
  logic [15:0] stat_corr_q, stat_unc_q;

  // Saturating frame counters, bumped when a result is accepted; clear wins
  always_ff @(posedge clk) begin
    if (!rstn || stat_clr) begin
      stat_corr_q <= '0;
      stat_unc_q  <= '0;
    end else if (out_valid && out_ready) begin
      if ((num_err_q != 2'd0) && (stat_corr_q != 16'hFFFF)) stat_corr_q <= stat_corr_q + 16'd1;
      if (uncorr_q && (stat_unc_q != 16'hFFFF))             stat_unc_q  <= stat_unc_q + 16'd1;
    end
  end

  assign stat_corrected = stat_corr_q;
  assign stat_uncorr    = stat_unc_q;
`endif

endmodule : bch_decoder_15_7
`default_nettype wire

// File: tb/tb_bch_decoder_15_7.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bch_decoder_15_7
//  Purpose  : Scoreboard bench for bch_decoder_15_7. Expected results come
//             from a brute-force nearest-codeword model over all 128
//             messages; a monitor checks latency, hold behaviour and data.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bch_decoder_15_7;

  localparam logic [8:0] G   = 9'h1D1;
  localparam int         LAT = 38;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [14:0] in_codeword = '0;
  logic        in_ready, out_valid, out_uncorrectable, busy;
  logic [6:0]  out_message;
  logic [14:0] out_corrected;
  logic [1:0]  out_num_err;
`ifdef BCH_DEC_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_corrected, stat_uncorr;
  int          mod_corr = 0, mod_unc = 0;
`endif

  bch_decoder_15_7 dut (
    .clk               (clk),
    .rstn              (rstn),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_codeword       (in_codeword),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_message       (out_message),
    .out_corrected     (out_corrected),
    .out_num_err       (out_num_err),
    .out_uncorrectable (out_uncorrectable),
    .busy              (busy)
`ifdef BCH_DEC_STATS_EN
    ,
    .stat_clr          (stat_clr),
    .stat_corrected    (stat_corrected),
    .stat_uncorr       (stat_uncorr)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [14:0] rx;
    logic [6:0]  msg;
    logic [14:0] corr;
    logic [1:0]  nerr;
    logic        unc;
    int          e0;
  } exp_t;

  exp_t sb[$];
  logic long_hold = 1'b0;

  logic [24:0] outs;
  assign outs = {out_message, out_corrected, out_num_err, out_uncorrectable};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // c(x) = m(x) * g(x) over GF(2)
  function automatic logic [14:0] encode(input logic [6:0] m);
    logic [14:0] c;
    c = '0;
    for (int i = 0; i < 7; i++)
      if (m[i]) c = c ^ ({6'b0, G} << i);
    return c;
  endfunction

  // Quotient of w(x) / g(x)
  function automatic logic [6:0] quot(input logic [14:0] w);
    logic [14:0] r;
    logic [6:0]  q;
    r = w;
    q = '0;
    for (int d = 6; d >= 0; d--) begin
      if (r[d+8]) begin
        q[d] = 1'b1;
        r = r ^ ({6'b0, G} << d);
      end
    end
    return q;
  endfunction

  // Bounded-distance decode: the unique codeword within distance 2, if any
  function automatic exp_t model(input logic [14:0] rx);
    exp_t        e;
    logic [14:0] cw;
    int          d;
    e.rx = rx; e.e0 = 0; e.unc = 1'b1; e.nerr = 2'd0; e.corr = rx; e.msg = quot(rx);
    for (int m = 0; m < 128; m++) begin
      cw = encode(7'(m));
      d  = $countones(cw ^ rx);
      if (d <= 2) begin
        e.unc = 1'b0; e.nerr = 2'(d); e.corr = cw; e.msg = 7'(m);
      end
    end
    return e;
  endfunction

  function automatic logic [14:0] rand_err(input int w);
    logic [14:0] e;
    int          p;
    e = '0;
    while ($countones(e) < w) begin
      p = int'($urandom_range(14, 0));
      e[p] = 1'b1;
    end
    return e;
  endfunction

  // Offer a word (called at a negedge); record the capturing edge index
  task automatic send(input logic [14:0] w, input exp_t e);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_codeword = w;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout: in_ready=0 expected=1");
    end else begin
      e.e0 = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout: pending=%0d expected=0", sb.size());
    end
  endtask

  // Monitor / scoreboard
  logic        mon_first = 1'b1;
  logic        mon_just_acc = 1'b0;
  int          mon_held = 0;
  logic [24:0] mon_snap = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        mon_first = 1'b1; mon_just_acc = 1'b0; mon_held = 0; out_ready = 1'b0;
      end else begin
        if (mon_just_acc) begin
          chk("idle_after_accept {out_valid,in_ready}", {30'b0, out_valid, in_ready}, 32'h1);
          mon_just_acc = 1'b0;
        end
        if (out_valid) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL spurious_output: out_valid=1 expected=0");
            out_ready = 1'b1;
          end else begin
            if (mon_first) begin
              chk($sformatf("latency rx=%h", sb[0].rx), cyc, sb[0].e0 + LAT);
              mon_snap = outs; mon_first = 1'b0; mon_held = 0;
            end else begin
              chk("hold_stable", {7'b0, outs}, {7'b0, mon_snap});
              chk("hold {in_ready,busy}", {30'b0, in_ready, busy}, 32'h1);
            end
            if (long_hold && mon_held < 10) out_ready = 1'b0;
            else                            out_ready = ($urandom_range(3, 0) != 0);
            if (out_ready) begin
              chk($sformatf("message rx=%h", sb[0].rx),   {25'b0, out_message},       {25'b0, sb[0].msg});
              chk($sformatf("corrected rx=%h", sb[0].rx), {17'b0, out_corrected},     {17'b0, sb[0].corr});
              chk($sformatf("num_err rx=%h", sb[0].rx),   {30'b0, out_num_err},       {30'b0, sb[0].nerr});
              chk($sformatf("uncorr rx=%h", sb[0].rx),    {31'b0, out_uncorrectable}, {31'b0, sb[0].unc});
`ifdef BCH_DEC_STATS_EN
              if (sb[0].nerr != 2'd0) mod_corr++;
              if (sb[0].unc)          mod_unc++;
`endif
              void'(sb.pop_front());
              mon_first = 1'b1; mon_just_acc = 1'b1; long_hold = 1'b0;
            end else begin
              mon_held++;
            end
          end
        end else begin
          out_ready = 1'b0;
        end
      end
    end
  end

  // Stimulus
  exp_t        ex;
  logic [14:0] w;
  logic [6:0]  m;
  initial begin
    repeat (3) @(negedge clk);
    chk("reset {in_ready,out_valid,busy}", {29'b0, in_ready, out_valid, busy}, 32'h4);
    chk("reset outputs", {7'b0, outs}, 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    // Directed vectors with hand-derived results
    ex = '{rx: 15'h0000, msg: 7'h00, corr: 15'h0000, nerr: 2'd0, unc: 1'b0, e0: 0};
    send(15'h0000, ex);
    ex = '{rx: 15'h41D1, msg: 7'h01, corr: 15'h01D1, nerr: 2'd1, unc: 1'b0, e0: 0};
    send(15'h41D1, ex);
    ex = '{rx: 15'h0150, msg: 7'h01, corr: 15'h01D1, nerr: 2'd2, unc: 1'b0, e0: 0};
    send(15'h0150, ex);
    drain();

    // Long backpressure with in_valid held high while DONE
    long_hold = 1'b1;
    w = encode(7'h5A) ^ rand_err(2);
    send(w, model(w));
    w = encode(7'h33) ^ rand_err(1);
    send(w, model(w));
    drain();

    // Every message with a random 0..3-bit error pattern, then random words
    for (int i = 0; i < 128; i++) begin
      w = encode(7'(i)) ^ rand_err(int'($urandom_range(3, 0)));
      send(w, model(w));
    end
    for (int i = 0; i < 400; i++) begin
      m = 7'($urandom_range(127, 0));
      w = encode(m) ^ rand_err(int'($urandom_range(3, 0)));
      send(w, model(w));
    end
    drain();

    // Reset during CHIEN discards the word
    w = encode(7'h7F) ^ rand_err(2);
    send(w, model(w));
    while (cyc < sb[$].e0 + 20) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("midreset {in_ready,out_valid,busy}", {29'b0, in_ready, out_valid, busy}, 32'h4);
    chk("midreset outputs", {7'b0, outs}, 32'h0);
    void'(sb.pop_back());
`ifdef BCH_DEC_STATS_EN
    mod_corr = 0; mod_unc = 0;
    chk("midreset stat_corrected", {16'b0, stat_corrected}, 32'h0);
`endif
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      w = encode(7'($urandom_range(127, 0))) ^ rand_err(int'($urandom_range(3, 0)));
      send(w, model(w));
    end
    drain();

`ifdef BCH_DEC_STATS_EN
    chk("stat_corrected", {16'b0, stat_corrected}, mod_corr);
    chk("stat_uncorr", {16'b0, stat_uncorr}, mod_unc);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    chk("stat_clr", {stat_corrected, stat_uncorr}, 32'h0);
`endif

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bch_decoder_15_7
`default_nettype wire
